// File: rtl/dipped_uio_arbiter_if.sv
// dipped_uio_arbiter_if: requester-side and pad-side signals of the uio bus arbiter
//   req/req_data/req_oe : per-requester request level, pad data and pad enable (8 bits each, packed)
//   gnt/owner/busy      : one-hot grant, current or last owner index, arbiter busy flag
//   uio_out/uio_oe      : pad data and pad output enable driven to the top-level uio pins
interface dipped_uio_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [8*NREQ-1:0] req_oe;
    logic [NREQ-1:0]   gnt;
    logic [OW-1:0]     owner;
    logic              busy;
    logic [7:0]        uio_out;
    logic [7:0]        uio_oe;
    modport master (output req, req_data, req_oe, input gnt, owner, busy, uio_out, uio_oe);
    modport slave  (input req, req_data, req_oe, output gnt, owner, busy, uio_out, uio_oe);
endinterface

// File: rtl/dipped_uio_arbiter.sv
// dipped_uio_arbiter: round-robin owner of the shared uio pads with bounded hold and tristated turnaround
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   i_ena  : design enable, low returns synchronously to IDLE keeping the owner
//   io_bus : requests and pad slices in, grant/owner/busy and muxed uio_out/uio_oe out
module dipped_uio_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic                 i_ena,
    dipped_uio_arbiter_if.slave io_bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
    state_t          r_state, w_state_nxt, w_arb_state;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt, w_arb_gnt;
    logic [OW-1:0]   r_owner, w_owner_nxt, w_arb_owner, w_win_idx, w_cand;
    logic [7:0]      r_hold, w_hold_nxt, w_arb_hold;
    logic [2:0]      r_turn, w_turn_nxt;
    logic            w_win_vld, w_release;
    logic [7:0]      w_uio_out, w_uio_oe;
    // Scan farthest-first so the nearest requester after the owner overwrites the rest.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = r_owner;
        w_cand    = r_owner;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = OW'((int'(r_owner) + k) % NREQ);
            if (io_bus.req[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end
    assign w_arb_state = w_win_vld ? OWN : IDLE;
    assign w_arb_gnt   = w_win_vld ? NREQ'(1) << w_win_idx : '0;
    assign w_arb_owner = w_win_vld ? w_win_idx : r_owner;
    assign w_arb_hold  = w_win_vld ? 8'd1 : 8'd0;
    // r_gnt is one-hot on the owner while in OWN, so masking it leaves only competitors.
    assign w_release = !io_bus.req[r_owner] ||
                       (r_hold == 8'(MAX_HOLD) && |(io_bus.req & ~r_gnt));
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold;
        w_turn_nxt  = r_turn;
        if (!i_ena) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_hold_nxt  = '0;
            w_turn_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = w_arb_state;
                    w_gnt_nxt   = w_arb_gnt;
                    w_owner_nxt = w_arb_owner;
                    w_hold_nxt  = w_arb_hold;
                end
                OWN: begin
                    if (w_release && TURNAROUND > 0) begin
                        w_state_nxt = TURN;
                        w_gnt_nxt   = '0;
                        w_hold_nxt  = '0;
                        w_turn_nxt  = 3'(TURNAROUND);
                    end else if (w_release) begin
                        w_state_nxt = w_arb_state;
                        w_gnt_nxt   = w_arb_gnt;
                        w_owner_nxt = w_arb_owner;
                        w_hold_nxt  = w_arb_hold;
                    end else begin
                        w_hold_nxt = (r_hold == 8'(MAX_HOLD)) ? r_hold : r_hold + 8'd1;
                    end
                end
                TURN: begin
                    // Last gap cycle arbitrates, so the gap is exactly TURNAROUND cycles.
                    if (r_turn <= 3'd1) begin
                        w_state_nxt = w_arb_state;
                        w_gnt_nxt   = w_arb_gnt;
                        w_owner_nxt = w_arb_owner;
                        w_hold_nxt  = w_arb_hold;
                        w_turn_nxt  = '0;
                    end else begin
                        w_turn_nxt = r_turn - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= OW'(NREQ - 1);
            r_hold  <= '0;
            r_turn  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_hold  <= w_hold_nxt;
            r_turn  <= w_turn_nxt;
        end
    end
    // One-hot grant lets an OR-mux select the owner's pad slice; no grant gives all zeros.
    always_comb begin
        w_uio_out = '0;
        w_uio_oe  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_uio_out = w_uio_out | io_bus.req_data[8*i +: 8];
                w_uio_oe  = w_uio_oe | io_bus.req_oe[8*i +: 8];
            end
        end
    end
    assign io_bus.gnt     = r_gnt;
    assign io_bus.owner   = r_owner;
    assign io_bus.busy    = (r_state != IDLE);
    assign io_bus.uio_out = w_uio_out;
    assign io_bus.uio_oe  = w_uio_oe;
endmodule

// File: tb/tb_dipped_uio_arbiter.sv
// tb_dipped_uio_arbiter: directed checks of grant, rotation, hold limit, turnaround, enable and reset
module tb_dipped_uio_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena0 = 1'b1;
    logic ena1 = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    dipped_uio_arbiter_if #(.NREQ(4)) bus0 ();
    dipped_uio_arbiter_if #(.NREQ(4)) bus1 ();
    dipped_uio_arbiter #(.NREQ(4), .MAX_HOLD(8), .TURNAROUND(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_ena(ena0), .io_bus(bus0));
    dipped_uio_arbiter #(.NREQ(4), .MAX_HOLD(8), .TURNAROUND(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_ena(ena1), .io_bus(bus1));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        bus0.req = 4'hF;
        bus1.req = 4'h0;
        tick();
        tick();
        n_checks++; if (bus0.gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt got=%b exp=%b", bus0.gnt, 4'b0000); end
        n_checks++; if (bus0.owner !== 2'd3) begin n_fail++; $display("FAIL rst_owner got=%0d exp=3", bus0.owner); end
        n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus0.busy); end
        n_checks++; if (bus0.uio_oe !== 8'h00) begin n_fail++; $display("FAIL rst_oe got=%h exp=00", bus0.uio_oe); end
        n_checks++; if (bus0.uio_out !== 8'h00) begin n_fail++; $display("FAIL rst_out got=%h exp=00", bus0.uio_out); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus0.gnt !== 4'b0001) begin n_fail++; $display("FAIL first_gnt got=%b exp=0001", bus0.gnt); end
        n_checks++; if (bus0.owner !== 2'd0) begin n_fail++; $display("FAIL first_owner got=%0d exp=0", bus0.owner); end
        n_checks++; if (bus0.uio_oe !== 8'hF1) begin n_fail++; $display("FAIL first_oe got=%h exp=f1", bus0.uio_oe); end
        n_checks++; if (bus0.uio_out !== 8'h11) begin n_fail++; $display("FAIL first_out got=%h exp=11", bus0.uio_out); end
        bus0.req = 4'h0;
        tick();
        tick();
        n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL first_idle busy got=%b exp=0", bus0.busy); end
    endtask
    task automatic test_single();
        bus0.req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (bus0.gnt !== 4'b0010 || bus0.uio_oe !== 8'hF2) begin n_fail++; $display("FAIL single_own c=%0d gnt=%b oe=%h exp gnt=0010 oe=f2", c, bus0.gnt, bus0.uio_oe); end
        end
        bus0.req = 4'b0000;
        tick();
        n_checks++; if (bus0.gnt !== 4'b0000 || bus0.busy !== 1'b1 || bus0.uio_oe !== 8'h00) begin n_fail++; $display("FAIL single_turn gnt=%b busy=%b oe=%h exp gnt=0000 busy=1 oe=00", bus0.gnt, bus0.busy, bus0.uio_oe); end
        tick();
        n_checks++; if (bus0.busy !== 1'b0 || bus0.owner !== 2'd1) begin n_fail++; $display("FAIL single_idle busy=%b owner=%0d exp busy=0 owner=1", bus0.busy, bus0.owner); end
    endtask
    task automatic test_rotation();
        logic [3:0] eg;
        logic [7:0] eo;
        bus0.req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            eg = 4'(1 << ((2 + n) % 4));
            eo = 8'hF1 + 8'((2 + n) % 4);
            for (int c = 0; c < 8; c++) begin
                tick();
                n_checks++; if (bus0.gnt !== eg || bus0.uio_oe !== eo) begin n_fail++; $display("FAIL rot_own n=%0d c=%0d gnt=%b oe=%h exp gnt=%b oe=%h", n, c, bus0.gnt, bus0.uio_oe, eg, eo); end
            end
            if (n < 4) begin
                tick();
                n_checks++; if (bus0.gnt !== 4'b0000 || bus0.uio_oe !== 8'h00 || bus0.busy !== 1'b1) begin n_fail++; $display("FAIL rot_gap n=%0d gnt=%b oe=%h busy=%b exp gnt=0000 oe=00 busy=1", n, bus0.gnt, bus0.uio_oe, bus0.busy); end
            end
        end
        bus0.req = 4'h0;
        tick();
        tick();
        n_checks++; if (bus0.busy !== 1'b0 || bus0.owner !== 2'd2) begin n_fail++; $display("FAIL rot_end busy=%b owner=%0d exp busy=0 owner=2", bus0.busy, bus0.owner); end
    endtask
    task automatic test_lone_hold();
        bus0.req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++; if (bus0.gnt !== 4'b0100) begin n_fail++; $display("FAIL lone_hold c=%0d got=%b exp=0100", c, bus0.gnt); end
        end
        bus0.req = 4'h0;
        tick();
        tick();
    endtask
    task automatic test_no_turnaround();
        bus1.req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++; if (bus1.gnt !== 4'b0001) begin n_fail++; $display("FAIL nota_own0 c=%0d got=%b exp=0001", c, bus1.gnt); end
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++; if (bus1.gnt !== 4'b0010) begin n_fail++; $display("FAIL nota_own1 c=%0d got=%b exp=0010", c, bus1.gnt); end
        end
        tick();
        n_checks++; if (bus1.gnt !== 4'b0001) begin n_fail++; $display("FAIL nota_back got=%b exp=0001", bus1.gnt); end
        bus1.req = 4'h0;
        tick();
        n_checks++; if (bus1.gnt !== 4'b0000 || bus1.busy !== 1'b0) begin n_fail++; $display("FAIL nota_idle gnt=%b busy=%b exp gnt=0000 busy=0", bus1.gnt, bus1.busy); end
    endtask
    task automatic test_ena();
        bus0.req = 4'b0010;
        tick();
        n_checks++; if (bus0.gnt !== 4'b0010 || bus0.owner !== 2'd1) begin n_fail++; $display("FAIL ena_own gnt=%b owner=%0d exp gnt=0010 owner=1", bus0.gnt, bus0.owner); end
        tick();
        ena0 = 1'b0;
        tick();
        n_checks++; if (bus0.gnt !== 4'b0000 || bus0.owner !== 2'd1 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL ena_low gnt=%b owner=%0d busy=%b exp gnt=0000 owner=1 busy=0", bus0.gnt, bus0.owner, bus0.busy); end
        ena0 = 1'b1;
        bus0.req = 4'b0011;
        tick();
        n_checks++; if (bus0.gnt !== 4'b0001 || bus0.owner !== 2'd0) begin n_fail++; $display("FAIL ena_wrap gnt=%b owner=%0d exp gnt=0001 owner=0", bus0.gnt, bus0.owner); end
        bus0.req = 4'h0;
        tick();
        tick();
    endtask
    task automatic test_async_reset();
        bus0.req = 4'b0100;
        tick();
        n_checks++; if (bus0.gnt !== 4'b0100) begin n_fail++; $display("FAIL areset_pre got=%b exp=0100", bus0.gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus0.gnt !== 4'b0000 || bus0.owner !== 2'd3 || bus0.busy !== 1'b0 || bus0.uio_oe !== 8'h00) begin n_fail++; $display("FAIL areset gnt=%b owner=%0d busy=%b oe=%h exp gnt=0000 owner=3 busy=0 oe=00", bus0.gnt, bus0.owner, bus0.busy, bus0.uio_oe); end
        bus0.req = 4'h0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask
    initial begin
        bus0.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus0.req_oe   = {8'hF4, 8'hF3, 8'hF2, 8'hF1};
        bus1.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus1.req_oe   = {8'hF4, 8'hF3, 8'hF2, 8'hF1};
        test_reset();
        test_single();
        test_rotation();
        test_lone_hold();
        test_no_turnaround();
        test_ena();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
